instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
- PC-driven fetch stage directly upstream of the instruction memory.
- Holds the program counter and drives the byte address to the memory combinationally.
- Captures the returned 32-bit word into an IF/ID output buffer with a valid/ready handshake toward decode.
- Handles stall, branch redirect/flush, and end-of-program halt.

Parameters:
- RESET_PC, 64'd0, PC value loaded on reset.
- IMEM_BYTES, 16, instruction memory size in bytes; fetch halts at this boundary.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- inst_address  out  64  byte address to instruction memory; equals current PC, combinational from the PC register.
- instruction  in  32  word returned by memory for inst_address, same cycle (combinational memory).
- branch_taken  in  1  redirect request from execute.
- branch_target  in  64  redirect byte address.
- id_ready  in  1  decode can accept a word this cycle.
- id_valid  out  1  id_instruction/id_pc hold a valid fetched word.
- id_pc  out  64  PC of the buffered word.
- id_instruction  out  32  buffered instruction word.
- halted  out  1  fetch stopped at end of memory.

Behaviour:
- Reset (async, immediate):
  - pc = RESET_PC; state = FETCH.
  - id_valid = 0; id_pc = 0; id_instruction = 32'h00000013 (NOP); halted = 0.
- States:
  - FETCH: issuing.
  - HALT: PC reached or passed IMEM_BYTES-3; no further fetch; halted = 1.
- accept = !id_valid || id_ready (buffer free or drained this cycle).
- FETCH with accept and no branch:
  - Buffer <= {pc, instruction}; id_valid <= 1; pc <= pc+4.
  - If pc+4 > IMEM_BYTES-4, next state = HALT.
- FETCH with !accept (stall): pc, buffer, and id_valid are all held; inst_address stays stable.
- Transfer: occurs when id_valid && id_ready. If no new fetch that cycle, id_valid <= 0.
- Latency: word at PC appears on id_instruction exactly 1 cycle after PC is on inst_address, with no stall.
- branch_taken (highest priority, any state, any accept):
  - id_valid <= 0 (flush, word discarded even if id_ready is low).
  - pc <= {branch_target[63:2], 2'b00} (low bits forced to zero).
  - state <= FETCH, unless the aligned target > IMEM_BYTES-4, in which case state <= HALT.
  - Nothing is fetched in the redirect cycle; the first word from the target is valid on the following cycle +1.
- HALT:
  - pc frozen; id_valid drains normally via id_ready.
  - Leaves HALT only on branch_taken to an in-range target, or on reset.
- PC arithmetic: 64-bit unsigned, wraps modulo 2^64 (unreachable in range-checked operation).
- Reset asserted mid-stall or mid-redirect: all state returns to reset values at once; the buffered word is lost.
- inst_address is never X: it always reflects the registered pc.

Optional Feature:
- Macro FETCH_PERF_COUNT_EN.
- Defined:
  - Adds output port fetch_count (32-bit), incremented on every buffer load (fetch), saturating at 32'hFFFFFFFF.
  - Adds output port stall_count (32-bit), incremented on every cycle in FETCH with !accept, also saturating.
  - Both counters reset to 0.
- Undefined: neither port nor counter logic exists; all other behaviour is identical.

Decomposition:
- Shared package fetch_pkg holds:
  - NOP_INSTR = 32'h00000013.
  - INSTR_BYTES = 4.
  - State encoding FETCH = 1'b0, HALT = 1'b1.
- One sub-module is natural: program_counter (64-bit register with async reset to RESET_PC, load-enable, next-value input), instantiated once.

Test Plan:
- Reset release, id_ready = 1, IMEM_BYTES = 16 -> inst_address 0, 4, 8, 12 on successive cycles; id_pc 0, 4, 8, 12 one cycle later; halted = 1 after the fetch at 12; id_valid drops after the last transfer.
- id_ready held low 3 cycles after the first fetch -> id_pc = 0, id_valid = 1, inst_address = 4 all stable; resume -> id_pc = 4 next.
- branch_taken with branch_target = 6 while id_valid = 1 and id_ready = 0 -> next cycle id_valid = 0, inst_address = 4; following cycle id_pc = 4.
- In HALT, branch_taken with target 0 -> halted = 0, refetch from 0; with target 64 -> remains halted.
- Async reset asserted mid-stall -> outputs are reset values immediately (id_instruction = 32'h00000013, id_valid = 0, inst_address = RESET_PC) without waiting for a clock.
- FETCH_PERF_COUNT_EN defined, full 16-byte run with one 2-cycle stall -> fetch_count = 4, stall_count = 2.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and state encoding for the instruction fetch stage
package fetch_pkg;
  localparam logic [31:0] NOP_INSTR   = 32'h00000013;
  localparam int          INSTR_BYTES = 4;

  typedef enum logic {
    FETCH = 1'b0,
    HALT  = 1'b1
  } fetch_state_e;
endpackage

// File: rtl/program_counter.sv
// rtl/program_counter.sv - 64-bit program counter register with load enable
module program_counter #(
  parameter logic [63:0] RESET_PC = 64'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_en,
  input  logic [63:0] pc_d,
  output logic [63:0] pc_q
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else if (load_en) begin
      pc_q <= pc_d;
    end
  end
endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - PC-driven fetch stage with IF/ID buffer, redirect and halt
// Optional fetch/stall performance counters under FETCH_PERF_COUNT_EN.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC   = 64'd0,
  parameter int          IMEM_BYTES = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic [63:0] inst_address,
  input  logic [31:0] instruction,
  input  logic        branch_taken,
  input  logic [63:0] branch_target,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [63:0] id_pc,
  output logic [31:0] id_instruction,
  output logic        halted
`ifdef FETCH_PERF_COUNT_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);
  localparam logic [63:0] LAST_PC = 64'(IMEM_BYTES - INSTR_BYTES);

  fetch_state_e state_q, state_d;
  logic         id_valid_q, id_valid_d;
  logic [63:0]  id_pc_q, id_pc_d;
  logic [31:0]  id_instr_q, id_instr_d;
  logic [63:0]  pc_q, pc_d, pc_inc, aligned_target;
  logic         pc_load, accept, fetch_en, stall_en;

  program_counter #(.RESET_PC(RESET_PC)) u_pc (
    .clk     (clk),
    .reset   (reset),
    .load_en (pc_load),
    .pc_d    (pc_d),
    .pc_q    (pc_q)
  );

  always_comb begin
    state_d        = state_q;
    id_valid_d     = id_valid_q;
    id_pc_d        = id_pc_q;
    id_instr_d     = id_instr_q;
    pc_load        = 1'b0;
    pc_d           = pc_q;
    fetch_en       = 1'b0;
    accept         = !id_valid_q || id_ready;
    stall_en       = (state_q == FETCH) && !accept;
    pc_inc         = pc_q + 64'(INSTR_BYTES);
    aligned_target = branch_target & ~64'd3;

    // A redirect flushes the buffer even when decode is not draining it.
    if (branch_taken) begin
      id_valid_d = 1'b0;
      pc_load    = 1'b1;
      pc_d       = aligned_target;
      state_d    = (aligned_target > LAST_PC) ? HALT : FETCH;
    end else if (state_q == FETCH && accept) begin
      fetch_en   = 1'b1;
      id_valid_d = 1'b1;
      id_pc_d    = pc_q;
      id_instr_d = instruction;
      pc_load    = 1'b1;
      pc_d       = pc_inc;
      if (pc_inc > LAST_PC) state_d = HALT;
    end else if (id_valid_q && id_ready) begin
      id_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= FETCH;
      id_valid_q <= 1'b0;
      id_pc_q    <= 64'd0;
      id_instr_q <= NOP_INSTR;
    end else begin
      state_q    <= state_d;
      id_valid_q <= id_valid_d;
      id_pc_q    <= id_pc_d;
      id_instr_q <= id_instr_d;
    end
  end

  assign inst_address   = pc_q;
  assign id_valid       = id_valid_q;
  assign id_pc          = id_pc_q;
  assign id_instruction = id_instr_q;
  assign halted         = (state_q == HALT);

`ifdef FETCH_PERF_COUNT_EN
  logic [31:0] fetch_count_q, fetch_count_d, stall_count_q, stall_count_d;

  always_comb begin
    fetch_count_d = fetch_count_q;
    stall_count_d = stall_count_q;
    if (fetch_en && fetch_count_q != 32'hFFFFFFFF) fetch_count_d = fetch_count_q + 32'd1;
    if (stall_en && stall_count_q != 32'hFFFFFFFF) stall_count_d = stall_count_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_count_q <= 32'd0;
      stall_count_q <= 32'd0;
    end else begin
      fetch_count_q <= fetch_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign fetch_count = fetch_count_q;
  assign stall_count = stall_count_q;
`else
  logic unused_perf;
  assign unused_perf = fetch_en ^ stall_en;
`endif
endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - directed self-checking bench for instruction_fetch
module tb_instruction_fetch;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [63:0] inst_address;
  logic [31:0] instruction;
  logic        branch_taken = 1'b0;
  logic [63:0] branch_target = 64'd0;
  logic        id_ready = 1'b0;
  logic        id_valid;
  logic [63:0] id_pc;
  logic [31:0] id_instruction;
  logic        halted;
`ifdef FETCH_PERF_COUNT_EN
  logic [31:0] fetch_count, stall_count;
`endif

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  // Memory model: word = 0xC0DE0000 ^ address (upper address bits folded in).
  assign instruction = 32'hC0DE0000 ^ inst_address[31:0] ^ inst_address[63:32];

  instruction_fetch #(.RESET_PC(64'd0), .IMEM_BYTES(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .inst_address   (inst_address),
    .instruction    (instruction),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .id_ready       (id_ready),
    .id_valid       (id_valid),
    .id_pc          (id_pc),
    .id_instruction (id_instruction),
    .halted         (halted)
`ifdef FETCH_PERF_COUNT_EN
    ,
    .fetch_count    (fetch_count),
    .stall_count    (stall_count)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    branch_taken = 1'b0;
    id_ready     = 1'b0;
    reset        = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (inst_address !== 64'd0) begin fails++; $display("FAIL reset_addr got %h exp %h", inst_address, 64'd0); end
    checks++; if (id_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", id_valid); end
    checks++; if (id_pc !== 64'd0) begin fails++; $display("FAIL reset_pc got %h exp 0", id_pc); end
    checks++; if (id_instruction !== 32'h00000013) begin fails++; $display("FAIL reset_instr got %h exp 00000013", id_instruction); end
    checks++; if (halted !== 1'b0) begin fails++; $display("FAIL reset_halted got %b exp 0", halted); end
  endtask

  task automatic test_sequential();
    do_reset();
    id_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (inst_address !== 64'(4*i)) begin fails++; $display("FAIL seq_addr[%0d] got %h exp %h", i, inst_address, 64'(4*i)); end
      tick();
      checks++; if (id_valid !== 1'b1) begin fails++; $display("FAIL seq_valid[%0d] got %b exp 1", i, id_valid); end
      checks++; if (id_pc !== 64'(4*i)) begin fails++; $display("FAIL seq_pc[%0d] got %h exp %h", i, id_pc, 64'(4*i)); end
      checks++; if (id_instruction !== (32'hC0DE0000 | 32'(4*i))) begin fails++; $display("FAIL seq_instr[%0d] got %h exp %h", i, id_instruction, 32'hC0DE0000 | 32'(4*i)); end
      checks++; if (halted !== (i == 3)) begin fails++; $display("FAIL seq_halted[%0d] got %b exp %b", i, halted, (i == 3)); end
    end
    tick();
    checks++; if (id_valid !== 1'b0) begin fails++; $display("FAIL seq_drain_valid got %b exp 0", id_valid); end
    checks++; if (inst_address !== 64'd16) begin fails++; $display("FAIL seq_halt_addr got %h exp 10", inst_address); end
    tick();
    checks++; if (id_valid !== 1'b0 || halted !== 1'b1) begin fails++; $display("FAIL seq_halt_hold got valid=%b halted=%b exp valid=0 halted=1", id_valid, halted); end
  endtask

  task automatic test_stall();
    do_reset();
    id_ready = 1'b1;
    tick();
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (id_pc !== 64'd0 || id_valid !== 1'b1 || inst_address !== 64'd4)
        begin fails++; $display("FAIL stall_hold[%0d] got pc=%h valid=%b addr=%h exp pc=0 valid=1 addr=4", i, id_pc, id_valid, inst_address); end
    end
    id_ready = 1'b1;
    tick();
    checks++; if (id_pc !== 64'd4 || id_instruction !== 32'hC0DE0004) begin fails++; $display("FAIL stall_resume got pc=%h instr=%h exp pc=4 instr=c0de0004", id_pc, id_instruction); end
    checks++; if (inst_address !== 64'd8) begin fails++; $display("FAIL stall_resume_addr got %h exp 8", inst_address); end
  endtask

  task automatic test_branch_flush();
    do_reset();
    id_ready = 1'b1;
    tick();
    id_ready      = 1'b0;
    branch_taken  = 1'b1;
    branch_target = 64'd6;
    tick();
    branch_taken = 1'b0;
    checks++; if (id_valid !== 1'b0) begin fails++; $display("FAIL flush_valid got %b exp 0", id_valid); end
    checks++; if (inst_address !== 64'd4) begin fails++; $display("FAIL flush_addr got %h exp 4", inst_address); end
    tick();
    checks++; if (id_valid !== 1'b1 || id_pc !== 64'd4 || id_instruction !== 32'hC0DE0004)
      begin fails++; $display("FAIL flush_refetch got valid=%b pc=%h instr=%h exp valid=1 pc=4 instr=c0de0004", id_valid, id_pc, id_instruction); end
  endtask

  task automatic test_halt_redirect();
    do_reset();
    id_ready = 1'b1;
    repeat (4) tick();
    checks++; if (halted !== 1'b1) begin fails++; $display("FAIL halt_reached got %b exp 1", halted); end
    branch_taken  = 1'b1;
    branch_target = 64'd0;
    tick();
    branch_taken = 1'b0;
    checks++; if (halted !== 1'b0 || inst_address !== 64'd0 || id_valid !== 1'b0)
      begin fails++; $display("FAIL halt_exit got halted=%b addr=%h valid=%b exp halted=0 addr=0 valid=0", halted, inst_address, id_valid); end
    tick();
    checks++; if (id_valid !== 1'b1 || id_pc !== 64'd0) begin fails++; $display("FAIL halt_refetch got valid=%b pc=%h exp valid=1 pc=0", id_valid, id_pc); end
    repeat (3) tick();
    checks++; if (halted !== 1'b1 || id_pc !== 64'd12) begin fails++; $display("FAIL halt_again got halted=%b pc=%h exp halted=1 pc=c", halted, id_pc); end
    branch_taken  = 1'b1;
    branch_target = 64'd64;
    tick();
    branch_taken = 1'b0;
    tick();
    checks++; if (halted !== 1'b1 || inst_address !== 64'd64 || id_valid !== 1'b0)
      begin fails++; $display("FAIL halt_oor got halted=%b addr=%h valid=%b exp halted=1 addr=40 valid=0", halted, inst_address, id_valid); end
  endtask

  task automatic test_async_reset();
    do_reset();
    id_ready = 1'b1;
    tick();
    id_ready = 1'b0;
    tick();
    #2;
    reset = 1'b1;
    #1;
    checks++; if (id_instruction !== 32'h00000013 || id_valid !== 1'b0 || inst_address !== 64'd0 || id_pc !== 64'd0 || halted !== 1'b0)
      begin fails++; $display("FAIL async_reset got instr=%h valid=%b addr=%h pc=%h halted=%b exp 00000013/0/0/0/0", id_instruction, id_valid, inst_address, id_pc, halted); end
    tick();
    reset = 1'b0;
  endtask

`ifdef FETCH_PERF_COUNT_EN
  task automatic test_perf_counts();
    do_reset();
    checks++; if (fetch_count !== 32'd0 || stall_count !== 32'd0) begin fails++; $display("FAIL perf_reset got fetch=%0d stall=%0d exp 0/0", fetch_count, stall_count); end
    id_ready = 1'b1;
    tick();
    id_ready = 1'b0;
    repeat (2) tick();
    id_ready = 1'b1;
    repeat (3) tick();
    checks++; if (halted !== 1'b1) begin fails++; $display("FAIL perf_halted got %b exp 1", halted); end
    checks++; if (fetch_count !== 32'd4) begin fails++; $display("FAIL perf_fetch got %0d exp 4", fetch_count); end
    checks++; if (stall_count !== 32'd2) begin fails++; $display("FAIL perf_stall got %0d exp 2", stall_count); end
  endtask
`endif

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_branch_flush();
    test_halt_redirect();
    test_async_reset();
`ifdef FETCH_PERF_COUNT_EN
    test_perf_counts();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
